// File: rtl/mod_key_engine_if.sv
// ---------------------------------------------------------------------------
// mod_key_engine_if
// Request/response bundle for the modular key/cipher engine.
//   start        : request pulse from the requester
//   mode         : 00 keygen, 01 encrypt, 10 decrypt, 11 invalid
//   secret_key   : Sk operand (W bits)
//   data_in      : plaintext D or ciphertext C (W bits)
//   result       : Pk, C or D produced by the engine (W bits)
//   ready        : one-cycle pulse, result updated
//   busy         : operation in progress
//   err_*        : validation flags latched at the last start
// Modports: master = requester side, slave = engine side.
// ---------------------------------------------------------------------------
interface mod_key_engine_if #(
  parameter int W = 8
);
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] secret_key;
  logic [W-1:0] data_in;
  logic [W-1:0] result;
  logic         ready;
  logic         busy;
  logic         err_invalid_seckey;
  logic         err_invalid_data;
  logic         err_invalid_mode;

  modport master (
    output start, mode, secret_key, data_in,
    input  result, ready, busy,
    input  err_invalid_seckey, err_invalid_data, err_invalid_mode
  );

  modport slave (
    input  start, mode, secret_key, data_in,
    output result, ready, busy,
    output err_invalid_seckey, err_invalid_data, err_invalid_mode
  );
endinterface

// File: rtl/mod_key_engine.sv
// ---------------------------------------------------------------------------
// mod_key_engine
// Modular key/cipher engine over GF(P) built on Pk = (Sk + Q) mod P.
//   keygen : result = (Sk + Q) mod P
//   encrypt: result = (D + Sk + Q) mod P
//   decrypt: result = (C - Sk - Q) mod P
// The unreduced sum is loaded into a W+2 bit register and reduced by at most
// one conditional subtraction of P per cycle (every load is < 3P, so at most
// two subtractions are ever needed).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mod_key_engine_if.slave request/response bundle
// ---------------------------------------------------------------------------
module mod_key_engine #(
  parameter int W = 8,
  parameter int P = 227,
  parameter int Q = 225
) (
  input  logic              clk,
  input  logic              rst_n,
  mod_key_engine_if.slave   bus
);

  localparam logic [W+1:0] P_S  = (W+2)'(P);
  localparam logic [W+1:0] Q_S  = (W+2)'(Q);
  localparam logic [W+1:0] P2_S = (W+2)'(2 * P);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REDUCE = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [W+1:0] r_sum;
  logic [W+1:0] w_sum_next;
  logic [W-1:0] r_result;
  logic [W-1:0] w_result_next;
  logic         r_ready;
  logic         w_ready_next;
  logic         r_busy;
  logic         w_busy_next;
  logic         r_err_seckey;
  logic         w_err_seckey_next;
  logic         r_err_data;
  logic         w_err_data_next;
  logic         r_err_mode;
  logic         w_err_mode_next;

  logic [W+1:0] w_sk_ext;
  logic [W+1:0] w_data_ext;
  logic         w_sk_bad;
  logic         w_data_bad;
  logic         w_mode_bad;
  logic [W+1:0] w_load_sum;

  assign w_sk_ext   = {2'b00, bus.secret_key};
  assign w_data_ext = {2'b00, bus.data_in};

  assign w_sk_bad   = (bus.secret_key == '0) || (w_sk_ext >= P_S);
  assign w_mode_bad = (bus.mode == 2'b11);
  // data_in only matters for encrypt/decrypt
  assign w_data_bad = ((bus.mode == 2'b01) || (bus.mode == 2'b10)) &&
                      (w_data_ext >= P_S);

  // Decrypt adds 2P before subtracting Sk + Q so the value stays positive
  // (Sk, Q <= P-1 guarantees a result >= 2); modular wrap of the intermediate
  // terms cancels out in W+2 bit arithmetic.
  always_comb begin
    w_load_sum = w_sk_ext + Q_S;
    case (bus.mode)
      2'b00:   w_load_sum = w_sk_ext + Q_S;
      2'b01:   w_load_sum = w_data_ext + w_sk_ext + Q_S;
      2'b10:   w_load_sum = w_data_ext + P2_S - w_sk_ext - Q_S;
      default: w_load_sum = w_sk_ext + Q_S;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_sum_next        = r_sum;
    w_result_next     = r_result;
    w_ready_next      = 1'b0;
    w_busy_next       = r_busy;
    w_err_seckey_next = r_err_seckey;
    w_err_data_next   = r_err_data;
    w_err_mode_next   = r_err_mode;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_err_seckey_next = w_sk_bad;
          w_err_data_next   = w_data_bad;
          w_err_mode_next   = w_mode_bad;
          if (!(w_sk_bad || w_data_bad || w_mode_bad)) begin
            w_sum_next   = w_load_sum;
            w_busy_next  = 1'b1;
            w_state_next = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        if (r_sum >= P_S) begin
          w_sum_next = r_sum - P_S;
        end else begin
          // r_sum < P < 2^W here, so the upper two bits are zero
          w_result_next = r_sum[W-1:0];
          w_ready_next  = 1'b1;
          w_busy_next   = 1'b0;
          w_state_next  = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sum        <= '0;
      r_result     <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_err_seckey <= 1'b0;
      r_err_data   <= 1'b0;
      r_err_mode   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sum        <= w_sum_next;
      r_result     <= w_result_next;
      r_ready      <= w_ready_next;
      r_busy       <= w_busy_next;
      r_err_seckey <= w_err_seckey_next;
      r_err_data   <= w_err_data_next;
      r_err_mode   <= w_err_mode_next;
    end
  end

  assign bus.result             = r_result;
  assign bus.ready              = r_ready;
  assign bus.busy               = r_busy;
  assign bus.err_invalid_seckey = r_err_seckey;
  assign bus.err_invalid_data   = r_err_data;
  assign bus.err_invalid_mode   = r_err_mode;

endmodule

// File: tb/tb_mod_key_engine.sv
// ---------------------------------------------------------------------------
// tb_mod_key_engine
// Directed bench for mod_key_engine with W=8, P=227, Q=225. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mod_key_engine;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  mod_key_engine_if #(.W(8)) bus ();

  mod_key_engine #(.W(8), .P(227), .Q(225)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Caller is positioned just after a falling edge. Drives a valid request,
  // follows it to ready and checks latency (n subtractions -> ready seen
  // n+1 falling edges after the accepting edge), busy and result.
  task automatic run_op(input string tag, input logic [1:0] md,
                        input logic [7:0] sk, input logic [7:0] d,
                        input logic [7:0] exp_res, input int exp_n,
                        input bit inject);
    bit got;
    int lat;
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.secret_key = sk;
    bus.data_in    = d;
    @(negedge clk);
    if (inject) begin
      // second request while busy: must be ignored
      bus.start      = 1'b1;
      bus.mode       = 2'b00;
      bus.secret_key = 8'd1;
      bus.data_in    = 8'd0;
    end else begin
      bus.start      = 1'b0;
      bus.secret_key = 8'hFF;
      bus.data_in    = 8'hFF;
    end
    check_eq({tag, " flags_clear"},
             {29'd0, bus.err_invalid_seckey, bus.err_invalid_data,
              bus.err_invalid_mode}, 32'd0);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.ready) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (!bus.busy) begin
        check_eq({tag, " busy_during_op"}, 32'(bus.busy), 32'd1);
      end
      @(negedge clk);
      if (k == 0 && inject) begin
        bus.start = 1'b0;
      end
    end
    check_eq({tag, " ready_seen"}, 32'(got), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_n + 1));
    check_eq({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check_eq({tag, " busy_at_ready"}, 32'(bus.busy), 32'd0);
  endtask

  // Rejected request: flags latched, no busy, no ready, result unchanged.
  task automatic err_op(input string tag, input logic [1:0] md,
                        input logic [7:0] sk, input logic [7:0] d,
                        input logic [2:0] exp_flags, input logic [7:0] old_res);
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.secret_key = sk;
    bus.data_in    = d;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, " flags"},
             {29'd0, bus.err_invalid_seckey, bus.err_invalid_data,
              bus.err_invalid_mode}, 32'(exp_flags));
    check_eq({tag, " busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " ready"}, 32'(bus.ready), 32'd0);
    check_eq({tag, " result_kept"}, 32'(bus.result), 32'(old_res));
    @(negedge clk);
    check_eq({tag, " ready_later"}, 32'(bus.ready), 32'd0);
    check_eq({tag, " flags_held"},
             {29'd0, bus.err_invalid_seckey, bus.err_invalid_data,
              bus.err_invalid_mode}, 32'(exp_flags));
  endtask

  initial begin
    n_cmp          = 0;
    n_mis          = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mode       = 2'b00;
    bus.secret_key = 8'd0;
    bus.data_in    = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("reset outputs",
             {19'd0, bus.result, bus.ready, bus.busy, bus.err_invalid_seckey,
              bus.err_invalid_data, bus.err_invalid_mode}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("keygen_sk5",   2'b00, 8'd5,   8'd0,   8'd3,   1, 1'b0);
    run_op("keygen_sk1",   2'b00, 8'd1,   8'd77,  8'd226, 0, 1'b0);
    run_op("keygen_sk226", 2'b00, 8'd226, 8'd0,   8'd224, 1, 1'b0);
    run_op("encrypt",      2'b01, 8'd100, 8'd200, 8'd71,  2, 1'b0);
    // started in the cycle the encrypt ready is high
    run_op("decrypt_b2b",  2'b10, 8'd100, 8'd71,  8'd200, 0, 1'b0);
    @(negedge clk);

    // flags packed as {seckey, data, mode}
    err_op("err_sk0",        2'b00, 8'd0,   8'd0,   3'b100, 8'd200);
    err_op("err_sk227",      2'b00, 8'd227, 8'd0,   3'b100, 8'd200);
    err_op("err_mode",       2'b11, 8'd5,   8'd250, 3'b001, 8'd200);
    err_op("err_enc_data",   2'b01, 8'd5,   8'd227, 3'b010, 8'd200);
    err_op("err_dec_data",   2'b10, 8'd5,   8'd230, 3'b010, 8'd200);
    err_op("err_mode_sk",    2'b11, 8'd0,   8'd250, 3'b101, 8'd200);
    run_op("clear_flags",    2'b00, 8'd5,   8'd0,   8'd3,   1, 1'b0);

    run_op("start_ignored",  2'b01, 8'd100, 8'd200, 8'd71,  2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_second_ready", 32'(bus.ready), 32'd0);
      check_eq("no_second_busy", 32'(bus.busy), 32'd0);
    end

    // reset during REDUCE of the D=200 encrypt
    bus.start      = 1'b1;
    bus.mode       = 2'b01;
    bus.secret_key = 8'd100;
    bus.data_in    = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("pre_reset busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset outputs",
             {19'd0, bus.result, bus.ready, bus.busy, bus.err_invalid_seckey,
              bus.err_invalid_data, bus.err_invalid_mode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_reset no_ready", 32'(bus.ready), 32'd0);
    end
    run_op("after_reset_keygen", 2'b00, 8'd5, 8'd0, 8'd3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
